varredura_matriz: RTL and testbench
===================================

VARREDURA_MATRIZ -- requirements
Module: varredura_matriz

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DIV_VARREDURA, default 5000, SHALL set the clock cycles each column stays selected (legal range 2..65535).
REQ-003 Parameter QUADROS_PISCA, default 25, SHALL set the frames per cursor blink half-period (legal range 1..255).
REQ-004 Port clock, input, 1: rising-edge system clock.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port habilitar, input, 1: scan enable; low blanks the matrix.
REQ-007 Ports coluna1_saida..coluna5_saida, input, 7 each: game image for each column, active-low; bit 0 = linha 1, bit 6 = linha 7.
REQ-008 Port cursor_coluna, input, 3: attack cursor column 1..5; any other value means no cursor.
REQ-009 Port cursor_linha, input, 3: attack cursor row 1..7; 0 means no cursor.
REQ-010 Port colunas, output, 5: column select, active-low one-cold; bit 0 = coluna 1.
REQ-011 Port linhas, output, 7: row data for the selected column, active-low.
REQ-012 Port fim_quadro, output, 1: one-cycle pulse at each frame snapshot.

Function
REQ-013 All outputs SHALL be driven from registers, with no combinational path from any input to any output.
REQ-014 Prescaler SHALL count 0..DIV_VARREDURA-1 and wrap; each wrap SHALL advance the column index 0→1→2→3→4→0.
REQ-015 Frame event SHALL be the prescaler wrap while index = 4.
- On that edge all five inputs SHALL be copied into a 5x7 frame buffer.
- fim_quadro SHALL be 1 for exactly the following cycle.
REQ-016 Between frame events the frame buffer SHALL hold its contents, so input changes mid-frame never tear the displayed image.
REQ-017 While the prescaler = 0, colunas SHALL be 5'b11111 (ghosting blank).
REQ-018 While the prescaler ≠ 0:
- colunas SHALL drive bit[index] low and all other bits high.
- linhas SHALL carry buffer[index].
REQ-019 Blink counter SHALL count frame events 0..QUADROS_PISCA-1; at wrap it SHALL toggle blink phase fase.
REQ-020 When the cursor is valid and index = cursor_coluna-1, linhas bit cursor_linha-1 SHALL be forced as follows; all other bits SHALL be unaffected.
- fase = 0: forced 0 (lit).
- fase = 1: forced 1 (dark).
REQ-021 Cursor inputs SHALL be sampled every cycle, not frame-buffered.
REQ-022 When habilitar = 0:
- Prescaler, index, blink counter and fase SHALL be held at 0.
- colunas SHALL be 5'b11111, linhas 7'b1111111, fim_quadro 0.
- The frame buffer SHALL load all five inputs every cycle.
REQ-023 On the first cycle with habilitar = 1, scanning SHALL start at index 0, prescaler 0, using the buffer loaded in the last disabled cycle.
REQ-024 If habilitar falls mid-frame, REQ-022 SHALL apply on the next edge; no partial frame state SHALL be retained.
REQ-025 The frame event and the blink wrap on the same edge SHALL both take effect, with fase toggled and the snapshot taken.

Reset
REQ-026 While reset = 1, the block SHALL asynchronously set:
- prescaler 0, index 0, blink counter 0, fase 0;
- frame buffer all 1s;
- colunas 5'b11111, linhas 7'b1111111, fim_quadro 0.
REQ-027 After reset deasserts, behaviour SHALL resume on the next rising edge per REQ-022/023.
REQ-028 Reset asserted mid-frame SHALL discard the frame in progress, and fim_quadro SHALL NOT pulse for it.

Verification (DIV_VARREDURA=4, QUADROS_PISCA=2)
REQ-029 Reset, habilitar=1, coluna1_saida=7'b1111110, others all 1s, no cursor -> expected response:
- colunas: 11111 for 1 cycle, then 11110 for 3 cycles, repeating over 11101, 11011, 10111, 01111.
- linhas = 1111110 while coluna 1 is selected.
- fim_quadro pulses every 20 cycles.
REQ-030 Change coluna3_saida to 7'b0000000 at index 1 -> expected response:
- The current frame shows the old coluna 3 value.
- The new value appears only after the next fim_quadro.
REQ-031 Cursor coluna=2, linha=3, all inputs 1s -> expected response:
- linhas = 1111011 during coluna 2 for 2 frames, then 1111111 for 2 frames, repeating.
- Other columns always show 1111111.
REQ-032 Cursor coluna=6 or linha=0 -> expected response: linhas always equal the buffered image; the cursor has no effect.
REQ-033 habilitar dropped at index 2 -> expected response:
- The next cycle shows colunas=11111, linhas=1111111.
- On re-enable, coluna 1 is selected after one blank cycle with the latest input image.
REQ-034 Reset pulse asserted between clock edges mid-frame -> expected response:
- Outputs go to reset values immediately, with no fim_quadro.
- The scan restarts at coluna 1.

Source files
------------

// File: rtl/varredura_matriz.sv
// varredura_matriz: multiplexed scan driver for a 5x7 LED matrix.
// The game image is frame-buffered so mid-frame input changes never tear the
// display. A column-change blank suppresses ghosting, and a blinking attack
// cursor is overlaid on the selected column.
module varredura_matriz #(
   parameter int unsigned DIV_VARREDURA = 5000,
   parameter int unsigned QUADROS_PISCA = 25
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilitar,
   input  logic [6:0] coluna1_saida,
   input  logic [6:0] coluna2_saida,
   input  logic [6:0] coluna3_saida,
   input  logic [6:0] coluna4_saida,
   input  logic [6:0] coluna5_saida,
   input  logic [2:0] cursor_coluna,
   input  logic [2:0] cursor_linha,
   output logic [4:0] colunas,
   output logic [6:0] linhas,
   output logic       fim_quadro
);

   localparam int unsigned PW = 16;
   localparam int unsigned BW = 8;
   localparam int unsigned NCOL = 5;
   localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV_VARREDURA - 1);
   localparam logic [BW-1:0] BLINK_MAX  = BW'(QUADROS_PISCA - 1);
   localparam logic [2:0]    ULTIMA_COL = 3'd4;

   logic [PW-1:0] r_presc;
   logic [2:0]    r_idx;
   logic [BW-1:0] r_blink;
   logic          r_fase;
   logic [6:0]    r_buf [NCOL];
   logic [4:0]    r_colunas;
   logic [6:0]    r_linhas;
   logic          r_fim;

   logic [PW-1:0] w_presc_nx;
   logic [2:0]    w_idx_nx;
   logic [BW-1:0] w_blink_nx;
   logic          w_fase_nx;
   logic          w_carrega;
   logic          w_quadro;
   logic [6:0]    w_entrada [NCOL];
   logic          w_cursor_ok;
   logic [2:0]    w_cursor_col;
   logic [2:0]    w_cursor_lin;
   logic [4:0]    w_colunas_nx;
   logic [6:0]    w_linhas_nx;

   assign w_entrada[0] = coluna1_saida;
   assign w_entrada[1] = coluna2_saida;
   assign w_entrada[2] = coluna3_saida;
   assign w_entrada[3] = coluna4_saida;
   assign w_entrada[4] = coluna5_saida;

   assign w_cursor_ok  = (cursor_coluna != 3'd0) && (cursor_coluna <= 3'd5) &&
                         (cursor_linha != 3'd0);
   assign w_cursor_col = cursor_coluna - 3'd1;
   assign w_cursor_lin = cursor_linha - 3'd1;

   // Next scan state: prescaler, column index, blink counter, buffer load.
   always_comb begin
      w_presc_nx = r_presc;
      w_idx_nx   = r_idx;
      w_blink_nx = r_blink;
      w_fase_nx  = r_fase;
      w_carrega  = 1'b0;
      w_quadro   = 1'b0;
      if (!habilitar) begin
         // Disabled: everything parked at zero, buffer tracks the inputs.
         w_presc_nx = '0;
         w_idx_nx   = '0;
         w_blink_nx = '0;
         w_fase_nx  = 1'b0;
         w_carrega  = 1'b1;
      end else if (r_presc == PRESC_MAX) begin
         w_presc_nx = '0;
         if (r_idx == ULTIMA_COL) begin
            w_idx_nx  = '0;
            w_carrega = 1'b1;
            w_quadro  = 1'b1;
            if (r_blink == BLINK_MAX) begin
               w_blink_nx = '0;
               w_fase_nx  = ~r_fase;
            end else begin
               w_blink_nx = r_blink + BW'(1);
            end
         end else begin
            w_idx_nx = r_idx + 3'd1;
         end
      end else begin
         w_presc_nx = r_presc + PW'(1);
      end
   end

   // Output image for the coming cycle; the buffer is never loaded on a cycle
   // that leads into a selected column, so reading r_buf here is safe.
   always_comb begin
      w_colunas_nx = 5'b11111;
      w_linhas_nx  = 7'b1111111;
      if (habilitar && (w_presc_nx != '0)) begin
         w_colunas_nx = ~(5'(1) << w_idx_nx);
         w_linhas_nx  = r_buf[w_idx_nx];
         if (w_cursor_ok && (w_idx_nx == w_cursor_col)) begin
            w_linhas_nx[w_cursor_lin] = w_fase_nx;
         end
      end
   end

   // Scan state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_blink <= '0;
         r_fase  <= 1'b0;
      end else begin
         r_presc <= w_presc_nx;
         r_idx   <= w_idx_nx;
         r_blink <= w_blink_nx;
         r_fase  <= w_fase_nx;
      end
   end

   // Frame buffer: snapshot at frame events or continuously while disabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCOL; i++) r_buf[i] <= 7'b1111111;
      end else if (w_carrega) begin
         for (int i = 0; i < NCOL; i++) r_buf[i] <= w_entrada[i];
      end
   end

   // Registered matrix drive and frame pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_colunas <= 5'b11111;
         r_linhas  <= 7'b1111111;
         r_fim     <= 1'b0;
      end else begin
         r_colunas <= w_colunas_nx;
         r_linhas  <= w_linhas_nx;
         r_fim     <= w_quadro;
      end
   end

   assign colunas    = r_colunas;
   assign linhas     = r_linhas;
   assign fim_quadro = r_fim;

endmodule

// File: tb/tb_varredura_matriz.sv
// tb_varredura_matriz: scoreboard bench for varredura_matriz with
// DIV_VARREDURA=4 and QUADROS_PISCA=2 (20-cycle frames, blink every 2 frames).
module tb_varredura_matriz;

   typedef struct {
      logic [4:0] col;
      logic [6:0] lin;
      logic       fim;
      bit         chk_lin;
      int         scen;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       hab;
   logic [6:0] in_img [5];
   logic [2:0] cur_c;
   logic [2:0] cur_l;
   logic [4:0] colunas;
   logic [6:0] linhas;
   logic       fim;

   logic [6:0] disp [5];
   exp_t       exp_q [$];
   int         scen = 0;
   int         n_checks = 0;
   int         n_err = 0;

   varredura_matriz #(
      .DIV_VARREDURA(4),
      .QUADROS_PISCA(2)
   ) dut (
      .clock        (clk),
      .reset        (rst),
      .habilitar    (hab),
      .coluna1_saida(in_img[0]),
      .coluna2_saida(in_img[1]),
      .coluna3_saida(in_img[2]),
      .coluna4_saida(in_img[3]),
      .coluna5_saida(in_img[4]),
      .cursor_coluna(cur_c),
      .cursor_linha (cur_l),
      .colunas      (colunas),
      .linhas       (linhas),
      .fim_quadro   (fim)
   );

   always #5 clk = ~clk;

   // Expected outputs c cycles after enable: 4-cycle column slots, first
   // cycle of each slot blank, 20-cycle frames, blink phase flips every 40.
   function automatic exp_t model_at(int c);
      exp_t       e;
      int         p;
      int         idx;
      logic [6:0] row;
      p         = c % 20;
      idx       = p / 4;
      e.fim     = (c > 0) && (p == 0);
      e.chk_lin = (p % 4) != 0;
      e.col     = 5'b11111;
      e.lin     = 7'b1111111;
      if (e.chk_lin) begin
         e.col[idx] = 1'b0;
         row = disp[idx];
         if (cur_c >= 3'd1 && cur_c <= 3'd5 && cur_l >= 3'd1 && (int'(cur_c) - 1) == idx)
            row[cur_l - 3'd1] = ((c / 40) % 2) == 1;
         e.lin = row;
      end
      e.scen = scen;
      e.cyc  = c;
      return e;
   endfunction

   function automatic exp_t blank_exp(int c);
      exp_t e;
      e.col     = 5'b11111;
      e.lin     = 7'b1111111;
      e.fim     = 1'b0;
      e.chk_lin = 1'b1;
      e.scen    = scen;
      e.cyc     = c;
      return e;
   endfunction

   task automatic run_en(input int n, input int chg_at);
      hab = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         if (c % 20 == 0) for (int k = 0; k < 5; k++) disp[k] = in_img[k];
         exp_q.push_back(model_at(c));
         if (c == chg_at) in_img[2] = 7'b0000000;
      end
   endtask

   task automatic run_dis(input int n);
      hab = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 5; k++) disp[k] = in_img[k];
         exp_q.push_back(blank_exp(c));
      end
   endtask

   task automatic set_img(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                          input logic [6:0] d, input logic [6:0] e);
      in_img[0] = a; in_img[1] = b; in_img[2] = c; in_img[3] = d; in_img[4] = e;
   endtask

   // Monitor: one expected entry per cycle, compared away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (colunas !== e.col || fim !== e.fim || (e.chk_lin && linhas !== e.lin)) begin
               n_err++;
               $display("FAIL scen%0d cyc%0d: got colunas=%b linhas=%b fim=%b, expected colunas=%b linhas=%b%s fim=%b",
                        e.scen, e.cyc, colunas, linhas, fim, e.col, e.lin,
                        e.chk_lin ? "" : "(unchecked)", e.fim);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; hab = 1'b0; cur_c = 3'd0; cur_l = 3'd0;
      set_img(7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
      for (int k = 0; k < 5; k++) disp[k] = 7'h7f;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(blank_exp(0));
      rst = 1'b0;

      // Column 1 image, scan order, frame pulse; coluna3 change at index 1.
      scen = 1;
      set_img(7'b1111110, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
      run_dis(2);
      run_en(60, 26);

      // Disable at index 2, then re-enable with a new image.
      scen = 2;
      set_img(7'h7f, 7'b1011101, 7'h7f, 7'b0101010, 7'h7f);
      run_dis(2);
      run_en(10, -1);
      in_img[4] = 7'b0011001;
      run_dis(3);
      run_en(25, -1);

      // Blinking cursor at coluna 2, linha 3 over four frames.
      scen = 3;
      set_img(7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
      cur_c = 3'd2; cur_l = 3'd3;
      run_dis(2);
      run_en(85, -1);

      // Invalid cursor column: no overlay.
      scen = 4;
      set_img(7'b1110111, 7'b1010101, 7'h7f, 7'b0111111, 7'h7f);
      cur_c = 3'd6; cur_l = 3'd3;
      run_dis(2);
      run_en(25, -1);

      // Cursor linha 0: no overlay.
      scen = 5;
      cur_c = 3'd2; cur_l = 3'd0;
      run_dis(2);
      run_en(25, -1);

      // Reset asserted between edges just before a frame event.
      scen = 6;
      cur_c = 3'd0; cur_l = 3'd0;
      set_img(7'b1111110, 7'h7f, 7'h7f, 7'h7f, 7'b1000000);
      run_dis(2);
      run_en(18, -1);
      @(posedge clk); #2;
      rst = 1'b1;
      exp_q.push_back(blank_exp(19));
      @(posedge clk); #1;
      exp_q.push_back(blank_exp(20));
      rst = 1'b0;
      for (int k = 0; k < 5; k++) disp[k] = 7'h7f;
      run_en(25, -1);

      @(negedge clk); #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
